// File: rtl/lbdr_route_param_if.sv
// Flit handshake between the input FIFO/switch allocator and the LBDR route unit.
// The master drives the FIFO head and the grant; the slave (route unit) returns the port request and status.
interface lbdr_route_param_if #(
    parameter int COORD_W = 2
);
    logic                   empty;
    logic [2:0]             flit_id;
    logic [2*COORD_W-1:0]   dst_addr;
    logic                   grant;
    logic                   Nport;
    logic                   Eport;
    logic                   Wport;
    logic                   Sport;
    logic                   Lport;
    logic                   busy;
    logic                   err_unroutable;
    logic                   err_proto;

    modport master (
        output empty, flit_id, dst_addr, grant,
        input  Nport, Eport, Wport, Sport, Lport, busy, err_unroutable, err_proto
    );

    modport slave (
        input  empty, flit_id, dst_addr, grant,
        output Nport, Eport, Wport, Sport, Lport, busy, err_unroutable, err_proto
    );
endinterface

// File: rtl/lbdr_route_param.sv
// Next-generation LBDR route unit: one-hot port per packet, held from HEADER until granted TAIL.
// Optional deroute fallback enabled by defining LBDR_DEROUTE_EN.
module lbdr_route_param #(
    parameter int COORD_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           Rxy_rst,
    input  logic [3:0]           Cx_rst,
    input  logic [2*COORD_W-1:0] cur_addr_rst,
    input  logic [1:0]           dr_rst,
    lbdr_route_param_if.slave    bus
);
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HDR_WAIT = 2'b01,
        BODY     = 2'b10
    } state_t;

    // Port vectors are ordered {L,N,E,W,S}, which is also the selection priority.
    function automatic logic [4:0] pick_first(input logic [4:0] cand);
        logic [4:0] res;
        res = 5'b00000;
        for (int i = 4; i >= 0; i--) begin
            if (cand[i] && (res == 5'b00000)) begin
                res[i] = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [4:0]             port_q, port_d;
    logic                   err_unr_q, err_unr_d;
    logic                   err_proto_q, err_proto_d;
    logic [7:0]             rxy_q;
    logic [3:0]             cx_q;
    logic [2*COORD_W-1:0]   cur_q;

    logic [COORD_W-1:0]     x_cur_s, y_cur_s, x_dst_s, y_dst_s;
    logic                   n1_s, s1_s, e1_s, w1_s;
    logic [4:0]             cand_s;
    logic [4:0]             min_sel_s;
    logic [4:0]             sel_s;

    assign x_cur_s = cur_q[COORD_W-1:0];
    assign y_cur_s = cur_q[2*COORD_W-1:COORD_W];
    assign x_dst_s = bus.dst_addr[COORD_W-1:0];
    assign y_dst_s = bus.dst_addr[2*COORD_W-1:COORD_W];

    assign n1_s = (y_dst_s < y_cur_s);
    assign s1_s = (y_cur_s < y_dst_s);
    assign e1_s = (x_cur_s < x_dst_s);
    assign w1_s = (x_dst_s < x_cur_s);

    // Rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, Cx = {Cs,Cw,Ce,Cn}
    assign cand_s[4] = ~n1_s & ~s1_s & ~e1_s & ~w1_s;
    assign cand_s[3] = ((n1_s & ~e1_s & ~w1_s) | (n1_s & e1_s & rxy_q[0]) | (n1_s & w1_s & rxy_q[1])) & cx_q[0];
    assign cand_s[2] = ((e1_s & ~n1_s & ~s1_s) | (e1_s & n1_s & rxy_q[2]) | (e1_s & s1_s & rxy_q[3])) & cx_q[1];
    assign cand_s[1] = ((w1_s & ~n1_s & ~s1_s) | (w1_s & n1_s & rxy_q[4]) | (w1_s & s1_s & rxy_q[5])) & cx_q[2];
    assign cand_s[0] = ((s1_s & ~e1_s & ~w1_s) | (s1_s & e1_s & rxy_q[6]) | (s1_s & w1_s & rxy_q[7])) & cx_q[3];

    assign min_sel_s = pick_first(cand_s);

`ifdef LBDR_DEROUTE_EN
    logic [1:0] dr_q;
    logic [4:0] dr_vec_s;

    // Deroute code N/E/W/S (0..3) doubles as the index of its Cx bit.
    always_comb begin
        dr_vec_s = 5'b00000;
        case (dr_q)
            2'b00:   dr_vec_s = 5'b01000;
            2'b01:   dr_vec_s = 5'b00100;
            2'b10:   dr_vec_s = 5'b00010;
            2'b11:   dr_vec_s = 5'b00001;
            default: dr_vec_s = 5'b00000;
        endcase
    end

    // Fall back to the deroute port only when minimal routing found nothing.
    always_comb begin
        sel_s = min_sel_s;
        if ((min_sel_s == 5'b00000) && !cand_s[4] && cx_q[dr_q]) begin
            sel_s = dr_vec_s;
        end else begin
            sel_s = min_sel_s;
        end
    end

    // Deroute configuration register, loaded only under reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q <= dr_rst;
        end else begin
            dr_q <= dr_q;
        end
    end
`else
    logic unused_dr_s;
    assign unused_dr_s = ^dr_rst;
    assign sel_s = min_sel_s;
`endif

    // Next-state, held-port and sticky-error logic.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        err_unr_d   = err_unr_q;
        err_proto_d = err_proto_q;
        case (state_q)
            IDLE: begin
                if (!bus.empty) begin
                    if (bus.flit_id == HEADER) begin
                        if (sel_s != 5'b00000) begin
                            port_d  = sel_s;
                            state_d = HDR_WAIT;
                        end else begin
                            err_unr_d = 1'b1;
                        end
                    end else begin
                        err_proto_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HDR_WAIT: begin
                if (bus.grant && !bus.empty) begin
                    state_d = BODY;
                end else begin
                    state_d = HDR_WAIT;
                end
            end
            BODY: begin
                if (!bus.empty) begin
                    if ((bus.flit_id == TAIL) && bus.grant) begin
                        state_d = IDLE;
                        port_d  = 5'b00000;
                    end else if (bus.flit_id == HEADER) begin
                        err_proto_d = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end else begin
                    state_d = BODY;
                end
            end
            default: begin
                state_d = IDLE;
                port_d  = 5'b00000;
            end
        endcase
    end

    // State, outputs and configuration registers; reset reloads config and abandons any route.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= 5'b00000;
            err_unr_q   <= 1'b0;
            err_proto_q <= 1'b0;
            rxy_q       <= Rxy_rst;
            cx_q        <= Cx_rst;
            cur_q       <= cur_addr_rst;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            err_unr_q   <= err_unr_d;
            err_proto_q <= err_proto_d;
            rxy_q       <= rxy_q;
            cx_q        <= cx_q;
            cur_q       <= cur_q;
        end
    end

    assign bus.Lport          = port_q[4];
    assign bus.Nport          = port_q[3];
    assign bus.Eport          = port_q[2];
    assign bus.Wport          = port_q[1];
    assign bus.Sport          = port_q[0];
    assign bus.busy           = (state_q != IDLE);
    assign bus.err_unroutable = err_unr_q;
    assign bus.err_proto      = err_proto_q;

    logic unused_payload_s;
    assign unused_payload_s = (PAYLOAD == 3'b000);
endmodule

// File: tb/tb_lbdr_route_param.sv
// Directed bench for lbdr_route_param; expected port vectors {L,N,E,W,S} are hand-derived.
module tb_lbdr_route_param;
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    logic       clk;
    logic       rst;
    logic [7:0] Rxy_rst;
    logic [3:0] Cx_rst;
    logic [3:0] cur_addr_rst;
    logic [1:0] dr_rst;
    int         n_cmp;
    int         n_bad;

    lbdr_route_param_if #(.COORD_W(2)) bus ();

    lbdr_route_param #(.COORD_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rxy_rst      (Rxy_rst),
        .Cx_rst       (Cx_rst),
        .cur_addr_rst (cur_addr_rst),
        .dr_rst       (dr_rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ports();
        return {3'b000, bus.Lport, bus.Nport, bus.Eport, bus.Wport, bus.Sport};
    endfunction

    function automatic logic [7:0] status();
        return {5'b00000, bus.busy, bus.err_unroutable, bus.err_proto};
    endfunction

    task automatic drive(input logic e, input logic [2:0] id, input logic [3:0] dst, input logic g);
        bus.empty    = e;
        bus.flit_id  = id;
        bus.dst_addr = dst;
        bus.grant    = g;
    endtask

    task automatic do_reset(input logic [3:0] cx);
        rst    = 1'b1;
        Cx_rst = cx;
        tick();
        rst    = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        Rxy_rst      = 8'h3C;
        cur_addr_rst = 4'd5;
        dr_rst       = 2'b01;
        drive(1'b1, PAYLOAD, 4'd0, 1'b0);
        do_reset(4'hF);
        chk("reset_ports", ports(), 8'h00);
        chk("reset_status", status(), 8'h00);

        // HEADER to (3,1): straight east
        drive(1'b0, HEADER, 4'd7, 1'b0);
        tick();
        chk("east_port", ports(), 8'h04);
        chk("east_busy", status(), 8'h04);
        drive(1'b0, HEADER, 4'd7, 1'b1);
        tick();
        drive(1'b0, PAYLOAD, 4'd0, 1'b1);
        tick();
        chk("east_payload", ports(), 8'h04);
        drive(1'b0, TAIL, 4'd0, 1'b1);
        tick();
        chk("east_tail_ports", ports(), 8'h00);
        chk("east_tail_status", status(), 8'h00);

        // HEADER to (0,0): NW quadrant, Rnw=0 Rwn=1 -> west
        drive(1'b0, HEADER, 4'd0, 1'b0);
        tick();
        chk("west_port", ports(), 8'h02);
        drive(1'b0, HEADER, 4'd0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, PAYLOAD, 4'd0, 1'b1);
            tick();
            chk("west_payload", ports(), 8'h02);
            drive(1'b1, TAIL, 4'd0, 1'b1);
            tick();
            chk("west_gap", ports(), 8'h02);
        end
        drive(1'b0, TAIL, 4'd0, 1'b0);
        tick();
        chk("west_tail_nogrant", ports(), 8'h02);
        drive(1'b0, TAIL, 4'd0, 1'b1);
        tick();
        chk("west_done_ports", ports(), 8'h00);
        chk("west_done_status", status(), 8'h00);

        // dst == cur -> local
        drive(1'b0, HEADER, 4'd5, 1'b0);
        tick();
        chk("local_port", ports(), 8'h10);
        drive(1'b0, HEADER, 4'd5, 1'b1);
        tick();
        drive(1'b0, TAIL, 4'd5, 1'b1);
        tick();
        drive(1'b1, TAIL, 4'd0, 1'b0);
        chk("local_done", status(), 8'h00);

        // local is chosen even with every Cx bit cleared
        do_reset(4'h0);
        drive(1'b0, HEADER, 4'd5, 1'b0);
        tick();
        chk("local_cx0", ports(), 8'h10);
        drive(1'b1, TAIL, 4'd0, 1'b0);

        // south blocked (Cs=0)
        do_reset(4'h7);
        drive(1'b0, HEADER, 4'd13, 1'b0);
        tick();
        drive(1'b1, TAIL, 4'd0, 1'b0);
`ifdef LBDR_DEROUTE_EN
        chk("south_blocked_deroute", ports(), 8'h04);
        chk("south_blocked_status", status(), 8'h04);
`else
        chk("south_blocked_ports", ports(), 8'h00);
        chk("south_blocked_status", status(), 8'h02);
`endif

        // south and deroute (east) both disconnected
        do_reset(4'h5);
        drive(1'b0, HEADER, 4'd13, 1'b0);
        tick();
        drive(1'b1, TAIL, 4'd0, 1'b0);
        chk("unroutable_ports", ports(), 8'h00);
        chk("unroutable_status", status(), 8'h02);
        tick();
        chk("unroutable_sticky", status(), 8'h02);

        // PAYLOAD head while idle
        do_reset(4'hF);
        chk("reset_clears_err", status(), 8'h00);
        drive(1'b0, PAYLOAD, 4'd0, 1'b1);
        tick();
        drive(1'b1, PAYLOAD, 4'd0, 1'b0);
        chk("proto_idle_ports", ports(), 8'h00);
        chk("proto_idle_status", status(), 8'h01);

        // HEADER head while in BODY
        do_reset(4'hF);
        drive(1'b0, HEADER, 4'd7, 1'b0);
        tick();
        drive(1'b0, HEADER, 4'd7, 1'b1);
        tick();
        drive(1'b0, HEADER, 4'd0, 1'b0);
        tick();
        chk("proto_body_ports", ports(), 8'h04);
        chk("proto_body_status", status(), 8'h05);

        // reset mid-packet with a new Cx
        rst    = 1'b1;
        Cx_rst = 4'h7;
        drive(1'b0, PAYLOAD, 4'd0, 1'b1);
        tick();
        rst = 1'b0;
        chk("midrst_ports", ports(), 8'h00);
        chk("midrst_status", status(), 8'h00);
        drive(1'b0, HEADER, 4'd13, 1'b0);
        tick();
        drive(1'b1, TAIL, 4'd0, 1'b0);
`ifdef LBDR_DEROUTE_EN
        chk("midrst_newcx", ports(), 8'h04);
`else
        chk("midrst_newcx", ports(), 8'h00);
        chk("midrst_newcx_err", status(), 8'h02);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
